// File: rtl/bitlet_prim_buffer_loader_pkg.sv
// Shared helpers for the bitlet primitive buffer loader slice.
package bitlet_prim_buffer_loader_pkg;

    // Width of an index into an n-entry array, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bitlet_prim_mod_counter.sv
// Modulo-N up-counter with enable and synchronous clear; wraps N-1 -> 0.
module bitlet_prim_mod_counter
    import bitlet_prim_buffer_loader_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned CW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          last
);

    localparam logic [CW-1:0] LastVal = CW'(N - 1);

    assign last = (count == LastVal);

    // Count state; clear wins over enable, wrap keeps the index inside 0..N-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/bitlet_prim_buffer_loader.sv
// Streams N words into an N-entry buffer array, then holds the batch until taken.
module bitlet_prim_buffer_loader
    import bitlet_prim_buffer_loader_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_data,
    output logic                    enw,
    output logic [idx_width(N)-1:0] sel,
    output logic [W-1:0]            DO,
    output logic                    batch_valid,
    input  logic                    batch_ready
);

    localparam int unsigned SW = idx_width(N);

    localparam logic [1:0] EncLoad   = 2'd0;
    localparam logic [1:0] EncCommit = 2'd1;
    localparam logic [1:0] EncHold   = 2'd2;

    typedef enum logic [1:0] {
        StLoad   = EncLoad,
        StCommit = EncCommit,
        StHold   = EncHold
    } state_e;

    state_e        state;
    logic [SW-1:0] count;
    logic          count_last;
    logic          hs;

    // Gated by rst_n so the upstream never sees ready while reset is held.
    assign in_ready = rst_n && (state == StLoad) && !flush;
    assign hs       = in_valid && in_ready;

    bitlet_prim_mod_counter #(
        .N (N)
    ) u_word_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (hs),
        .clr   (flush),
        .count (count),
        .last  (count_last)
    );

    // Control FSM with registered write port and batch_valid; flush overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StLoad;
            enw         <= 1'b0;
            sel         <= '0;
            DO          <= '0;
            batch_valid <= 1'b0;
        end else if (flush) begin
            // sel/DO keep their values; array contents are left to be overwritten.
            state       <= StLoad;
            enw         <= 1'b0;
            batch_valid <= 1'b0;
        end else begin
            enw <= hs;
            if (hs) begin
                sel <= count;
                DO  <= in_data;
            end
            unique case (state)
                StLoad: begin
                    if (hs && count_last) begin
                        state <= StCommit;
                    end
                end
                StCommit: begin
                    state       <= StHold;
                    batch_valid <= 1'b1;
                end
                StHold: begin
                    if (batch_ready) begin
                        state       <= StLoad;
                        batch_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= StLoad;
                    batch_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bitlet_prim_buffer_loader.md
BITLET_PRIM_BUFFER_LOADER -- requirements
Module: bitlet_prim_buffer_loader

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of buffer-array entries per batch (N >= 2, need not be a power of 2).
REQ-002 SHALL have parameter W, default 16, meaning width of one data word.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous abort of the current batch, active high.
REQ-006 SHALL have port in_valid  input  1  upstream word valid.
REQ-007 SHALL have port in_ready  output  1  loader accepts a word this cycle.
REQ-008 SHALL have port in_data  input  W  upstream word.
REQ-009 SHALL have port enw  output  1  write strobe to the buffer array, 1 cycle per word.
REQ-010 SHALL have port sel  output  $clog2(N)  destination entry index for enw.
REQ-011 SHALL have port DO  output  W  write data to the buffer array.
REQ-012 SHALL have port batch_valid  output  1  all N entries written and visible at the buffer-array outputs.
REQ-013 SHALL have port batch_ready  input  1  downstream consumer has taken the batch.

Function
REQ-014 SHALL implement FSM states LOAD, COMMIT, HOLD; reset state LOAD.
REQ-015 SHALL drive in_ready = 1 only in LOAD and when flush = 0.
REQ-016 SHALL count accepted words: a handshake (in_valid & in_ready) with word count k SHALL register enw = 1, sel = k, DO = in_data for exactly the next cycle.
REQ-017 SHALL increment the word count per handshake, from 0 to N-1; after N-1 it SHALL return to 0, with no overflow into non-existent entries.
REQ-018 SHALL transition LOAD -> COMMIT on the handshake with count N-1; COMMIT lasts exactly one cycle, the final enw.
REQ-019 SHALL transition COMMIT -> HOLD unconditionally; batch_valid = 1 exactly in HOLD, i.e. from 2 cycles after the last handshake.
REQ-020 SHALL transition HOLD -> LOAD on batch_valid & batch_ready; in_ready rises the next cycle with count 0.
REQ-021 SHALL keep enw = 0 when no handshake occurred in the previous cycle; sel and DO SHALL hold their last values when enw = 0.
REQ-022 SHALL give flush priority over all events: next cycle state = LOAD, count = 0, enw = 0, batch_valid = 0; this applies even if a handshake or batch_ready coincides.
REQ-023 SHALL NOT clear buffer-array contents on flush; stale entries are overwritten by the next batch.
REQ-024 SHALL ignore in_data and in_valid when in_ready = 0; batch_ready outside HOLD SHALL have no effect.
REQ-025 SHALL treat in_valid held high across the LOAD -> COMMIT boundary as a stalled word, accepted only after re-entering LOAD.

Reset
REQ-026 SHALL on rst_n = 0 immediately force state LOAD, count 0, enw 0, sel 0, DO 0, batch_valid 0, in_ready 0 during reset.
REQ-027 SHALL abandon a partial batch when reset asserts mid-load, with no residual enw after release.
REQ-028 SHALL drive in_ready = 1 in the first cycle after release.

Structure
REQ-029 SHALL put the state encodings as localparams inside the module; no shared package is needed for them.
REQ-030 SHALL use one sub-module, bitlet_prim_mod_counter, a modulo-N up-counter with enable and synchronous clear, for the word count.
REQ-031 SHALL register all outputs except in_ready, which SHALL be decoded from state and flush.

Verification (N=4, W=16, paired with a 4-entry buffer array)
REQ-032 Bench SHALL cover: stream 0x1111,0x2222,0x3333,0x4444 with in_valid always high -> enw at sel 0,1,2,3 on consecutive cycles; batch_valid 2 cycles after the 4th handshake; array out = {0x4444,0x3333,0x2222,0x1111}.
REQ-033 Bench SHALL cover: batch_ready held 0 for 5 cycles in HOLD -> in_ready = 0 and no enw throughout; batch_ready = 1 -> LOAD next cycle, next word at sel 0.
REQ-034 Bench SHALL cover: in_valid gaps (words at cycles 0, 3, 4, 9) -> sel 0..3 in order, exactly 4 enw pulses, batch_valid after the 4th.
REQ-035 Bench SHALL cover: flush after 2 words, then 4 new words 0xA..0xD -> entries 0..3 = 0xA..0xD, batch_valid once.
REQ-036 Bench SHALL cover: flush coinciding with the 4th handshake -> no enw the next cycle, no batch_valid, count 0.
REQ-037 Bench SHALL cover: rst_n pulled low mid-batch, asynchronous to clk -> outputs 0 immediately; after release a full 4-word batch completes normally.
